mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_div_core.sv | 47 ++++
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the divide-by-zero quotient.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;
    localparam int          ITER_CYCLES     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on operand magnitudes; one quotient bit per step.
// quotient/remainder are the values after the step taken in the current cycle.
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_q, rem_q, dvsr_q;
    logic [32:0] shifted, diff;

    // The dividend shifts out of quo_q as quotient bits shift in.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        if (!diff[32]) begin
            remainder = diff[31:0];
            quotient  = {quo_q[30:0], 1'b1};
        end else begin
            remainder = shifted[31:0];
            quotient  = {quo_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
        end else if (step) begin
            quo_q  <= quotient;
            rem_q  <= remainder;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t state_q, state_d;
    logic [4:0]      count_q;
    logic [2:0]      f3_q;
    logic            neg_q;
    logic [XLEN-1:0] mcand_q, mul_hi_q, mul_lo_q, result_q;

    logic            accept, a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast_mul, fast;
    logic [XLEN-1:0] fast_val, fast_mul_val, final_val;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_step, mul_lo_step, quo_step, rem_step, quo_s, rem_s;
    logic [2*XLEN-1:0] prod, prod_s;

    assign accept = start && (state_q != CALC);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed_in = 1'b1;
                b_signed_in = 1'b1;
            end
            F3_MULHSU: a_signed_in = 1'b1;
            default: ;
        endcase
    end

    assign a_neg_in = a_signed_in & op_a[XLEN-1];
    assign b_neg_in = b_signed_in & op_b[XLEN-1];
    assign a_mag    = a_neg_in ? -op_a : op_a;
    assign b_mag    = b_neg_in ? -op_b : op_b;
    // The remainder takes the dividend's sign; everything else the product of signs.
    assign neg_in   = (funct3 == F3_REM || funct3 == F3_REMU) ? a_neg_in : (a_neg_in ^ b_neg_in);

    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_prod;
    assign fm_a         = {a_signed_in & op_a[XLEN-1], op_a};
    assign fm_b         = {b_signed_in & op_b[XLEN-1], op_b};
    assign fm_prod      = 64'(fm_a) * 64'(fm_b);
    assign fast_mul     = !funct3[2];
    assign fast_mul_val = (funct3 == F3_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
`else
    assign fast_mul     = 1'b0;
    assign fast_mul_val = '0;
`endif

    always_comb begin
        fast_val = fast_mul_val;
        if (div_zero)
            fast_val = funct3[1] ? op_a : DIV_BY_ZERO_QUO;
        else if (div_ovf)
            fast_val = funct3[1] ? '0 : op_a;
    end
    assign fast = fast_mul || div_zero || div_ovf;

    // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
    assign mul_sum     = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_step = mul_sum[XLEN:1];
    assign mul_lo_step = {mul_sum[0], mul_lo_q[XLEN-1:1]};
    assign prod        = {mul_hi_step, mul_lo_step};
    assign prod_s      = neg_q ? -prod : prod;

    muldiv_div_core u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      ((state_q == CALC) && f3_q[2]),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo_step),
        .remainder (rem_step)
    );

    assign quo_s     = neg_q ? -quo_step : quo_step;
    assign rem_s     = neg_q ? -rem_step : rem_step;
    assign final_val = f3_q[2] ? (f3_q[1] ? rem_s : quo_s)
                               : ((f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_comb begin
        state_d = state_q;
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = fast ? DONE : CALC;
                else
                    state_d = IDLE;
            end
            CALC: if (count_q == 5'(ITER_CYCLES - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: operand and accumulator registers are plain flops, so clearing them on reset is cheap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mul_hi_q <= '0;
            mul_lo_q <= '0;
            result_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            f3_q     <= funct3;
            neg_q    <= neg_in;
            mcand_q  <= b_mag;
            mul_hi_q <= '0;
            mul_lo_q <= a_mag;
            if (fast) result_q <= fast_val;
        end else if (state_q == CALC) begin
            count_q <= count_q + 5'd1;
            if (!f3_q[2]) begin
                mul_hi_q <= mul_hi_step;
                mul_lo_q <= mul_lo_step;
            end
            if (count_q == 5'(ITER_CYCLES - 1)) result_q <= final_val;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (honours MULDIV_FAST_MUL_EN if defined).
module tb_mul_div_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; drives a start request sampled on the next posedge.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
    endtask

    // Counts posedges after the launch until done; returns -1 latency on timeout.
    task automatic wait_done(input int glitch_at, output int lat, output int busy_cycles,
                             output logic [31:0] first_res);
        lat = -1;
        busy_cycles = 0;
        first_res = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == glitch_at);
            if (k == glitch_at) launch(F3_DIV, 32'd200, 32'd3);
            if (k == 1) first_res = result;
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        logic [31:0] fr;
        @(negedge clk);
        launch(f3, a, b);
        wait_done(0, lat, bc, fr);
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bc, (exp_lat == 33) ? 32 : 0);
    endtask

    initial begin
        int lat, bc, dones;
        logic [31:0] fr;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        run_op("mul_7_m3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu_m1_2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
        run_op("divu_5_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, FAST_LAT);
        run_op("rem_5_0", F3_REM, 32'd5, 32'd0, 32'd5, FAST_LAT);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FAST_LAT);

        // A start pulse mid-calculation must not disturb the operation in flight.
        @(negedge clk);
        launch(F3_DIVU, 32'd100, 32'd7);
        wait_done(10, lat, bc, fr);
        check("ignored_start_result", result, 32'd14);
        check("ignored_start_latency", lat, 33);

        // Reset during a calculation aborts it with no done pulse.
        @(negedge clk);
        launch(F3_DIV, 32'd1000, 32'd3);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Back-to-back: second start lands in the DONE cycle of the first.
        @(negedge clk);
        launch(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, lat, bc, fr);
        check("b2b_op1_latency", lat, MUL_LAT);
        check("b2b_op1_result", result, 32'hFFFF_FFEB);
        launch(F3_DIVU, 32'd100, 32'd7);
        wait_done(0, lat, bc, fr);
        check("b2b_op2_result_held", fr, 32'hFFFF_FFEB);
        check("b2b_op2_latency", lat, 33);
        check("b2b_op2_result", result, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
